// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 8-bit RISC-V pipeline.
// Performs loads/stores against an internal byte-wide RAM, resolves
// conditional branches and registers the MEM/WB pipeline outputs.
// After every reset the RAM is cleared one byte per cycle; mem_busy
// stays high for the whole clear so the hazard unit can stall upstream.
//
// Flow control: there is no valid/ready pair on this stage. Every cycle in
// RUN it consumes exactly one EX/MEM entry and produces one MEM/WB entry;
// stalling the pipeline while mem_busy is high is the hazard unit's job.
// While clearing (INIT), EX/MEM inputs are ignored and bubbles are emitted.
module mem_stage #(
  parameter int PC_SIZE    = 10,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_SIZE-1:0]    PC_jump_in,
  input  logic                  zero_in,
  input  logic [7:0]            ALU_result_in,
  input  logic [7:0]            write_data_in,
  input  logic [4:0]            write_register_in,
  input  logic                  branch_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  output logic [7:0]            ex_mem_alu_result,
  output logic                  pc_src,
  output logic [PC_SIZE-1:0]    PC_branch,
  output logic [7:0]            read_data,
  output logic [7:0]            ALU_result_out,
  output logic [4:0]            write_register_out,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic                  mem_busy,
  output logic                  dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_init_addr;
  logic [7:0]              r_mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_init_last;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_waddr;
  logic [7:0]              w_mem_wdata;
  logic [7:0]              w_load_data;
  logic                    w_pc_src;

  // Upper address bits are ignored so accesses wrap modulo the RAM depth.
  assign w_addr      = ALU_result_in[ADDR_WIDTH-1:0];
  assign w_init_last = (r_init_addr == {ADDR_WIDTH{1'b1}});

  // Combinational pass-throughs for forwarding and the PC mux.
  assign ex_mem_alu_result = ALU_result_in;
  assign PC_branch         = PC_jump_in;
  assign pc_src            = w_pc_src;

  // Moore status: busy exactly while the clear sequencer owns the RAM.
  assign mem_busy  = (r_state == ST_INIT);
  assign dbg_state = r_state;

  // State register; reset always restarts the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, RAM write port select and branch decision.
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_waddr  = w_addr;
    w_mem_wdata  = write_data_in;
    w_pc_src     = 1'b0;
    case (r_state)
      ST_INIT: begin
        // Clearing owns the write port; EX/MEM stores are dropped.
        if (!reset) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = r_init_addr;
          w_mem_wdata = 8'h00;
          if (w_init_last) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_pc_src = branch_in & zero_in;
        if (!reset && mem_write_in) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = w_addr;
          w_mem_wdata = write_data_in;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // Clear pointer: walks the whole RAM once per reset, then wraps to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= r_init_addr + 1'b1;
    end
  end

  // Single write port; no reset on the array, the sequencer clears it.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Asynchronous read sees pre-edge contents, so a same-address
  // load+store returns the old byte.
  always_comb begin
    w_load_data = 8'h00;
    if ((r_state == ST_RUN) && mem_read_in) begin
      w_load_data = r_mem[w_addr];
    end
  end

  // MEM/WB pipeline registers; bubbles during reset and clearing.
  always_ff @(posedge clock) begin
    if (reset || (r_state == ST_INIT)) begin
      read_data          <= 8'h00;
      ALU_result_out     <= 8'h00;
      write_register_out <= 5'd0;
      mem_to_reg_out     <= 1'b0;
      reg_write_out      <= 1'b0;
    end else begin
      read_data          <= w_load_data;
      ALU_result_out     <= ALU_result_in;
      write_register_out <= write_register_in;
      mem_to_reg_out     <= mem_to_reg_in;
      reg_write_out      <= reg_write_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one 256-byte instance and one 16-byte
// instance share the same EX/MEM stimulus.
module tb_mem_stage;

  logic        clock;
  logic        reset;
  logic [9:0]  PC_jump_in;
  logic        zero_in;
  logic [7:0]  ALU_result_in;
  logic [7:0]  write_data_in;
  logic [4:0]  write_register_in;
  logic        branch_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        mem_to_reg_in;
  logic        reg_write_in;

  logic [7:0]  a_ex_mem_alu_result;
  logic        a_pc_src;
  logic [9:0]  a_PC_branch;
  logic [7:0]  a_read_data;
  logic [7:0]  a_ALU_result_out;
  logic [4:0]  a_write_register_out;
  logic        a_mem_to_reg_out;
  logic        a_reg_write_out;
  logic        a_mem_busy;
  logic        a_dbg_state;

  logic [7:0]  b_ex_mem_alu_result;
  logic        b_pc_src;
  logic [9:0]  b_PC_branch;
  logic [7:0]  b_read_data;
  logic [7:0]  b_ALU_result_out;
  logic [4:0]  b_write_register_out;
  logic        b_mem_to_reg_out;
  logic        b_reg_write_out;
  logic        b_mem_busy;
  logic        b_dbg_state;

  int n_cmp;
  int n_err;

  mem_stage #(.PC_SIZE(10), .ADDR_WIDTH(8)) u_dut8 (
    .clock              (clock),
    .reset              (reset),
    .PC_jump_in         (PC_jump_in),
    .zero_in            (zero_in),
    .ALU_result_in      (ALU_result_in),
    .write_data_in      (write_data_in),
    .write_register_in  (write_register_in),
    .branch_in          (branch_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_to_reg_in      (mem_to_reg_in),
    .reg_write_in       (reg_write_in),
    .ex_mem_alu_result  (a_ex_mem_alu_result),
    .pc_src             (a_pc_src),
    .PC_branch          (a_PC_branch),
    .read_data          (a_read_data),
    .ALU_result_out     (a_ALU_result_out),
    .write_register_out (a_write_register_out),
    .mem_to_reg_out     (a_mem_to_reg_out),
    .reg_write_out      (a_reg_write_out),
    .mem_busy           (a_mem_busy),
    .dbg_state          (a_dbg_state)
  );

  mem_stage #(.PC_SIZE(10), .ADDR_WIDTH(4)) u_dut4 (
    .clock              (clock),
    .reset              (reset),
    .PC_jump_in         (PC_jump_in),
    .zero_in            (zero_in),
    .ALU_result_in      (ALU_result_in),
    .write_data_in      (write_data_in),
    .write_register_in  (write_register_in),
    .branch_in          (branch_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_to_reg_in      (mem_to_reg_in),
    .reg_write_in       (reg_write_in),
    .ex_mem_alu_result  (b_ex_mem_alu_result),
    .pc_src             (b_pc_src),
    .PC_branch          (b_PC_branch),
    .read_data          (b_read_data),
    .ALU_result_out     (b_ALU_result_out),
    .write_register_out (b_write_register_out),
    .mem_to_reg_out     (b_mem_to_reg_out),
    .reg_write_out      (b_reg_write_out),
    .mem_busy           (b_mem_busy),
    .dbg_state          (b_dbg_state)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset             = 1'b1;
    PC_jump_in        = 10'h155;
    zero_in           = 1'b1;
    branch_in         = 1'b1;
    ALU_result_in     = 8'h42;
    write_data_in     = 8'hEE;
    write_register_in = 5'd9;
    mem_read_in       = 1'b1;
    mem_write_in      = 1'b0;
    mem_to_reg_in     = 1'b1;
    reg_write_in      = 1'b1;

    // Reset held 3 cycles.
    tick();
    tick();
    tick();
    chk("rst_read_data", {8'h0, a_read_data}, 16'h0000);
    chk("rst_alu_out", {8'h0, a_ALU_result_out}, 16'h0000);
    chk("rst_wreg_out", {11'h0, a_write_register_out}, 16'h0000);
    chk("rst_m2r_out", {15'h0, a_mem_to_reg_out}, 16'h0000);
    chk("rst_rw_out", {15'h0, a_reg_write_out}, 16'h0000);
    chk("rst_busy8", {15'h0, a_mem_busy}, 16'h0001);
    chk("rst_busy4", {15'h0, b_mem_busy}, 16'h0001);
    chk("rst_pc_src", {15'h0, a_pc_src}, 16'h0000);
    chk("rst_ex_alu", {8'h0, a_ex_mem_alu_result}, 16'h0042);
    chk("rst_pc_branch", {6'h0, a_PC_branch}, 16'h0155);

    // Release; attempt a store to 0x00 throughout the clear (must be dropped).
    reset         = 1'b0;
    ALU_result_in = 8'h00;
    mem_write_in  = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("clr_busy8", {15'h0, a_mem_busy}, (i < 256) ? 16'h0001 : 16'h0000);
      chk("clr_busy4", {15'h0, b_mem_busy}, (i < 16) ? 16'h0001 : 16'h0000);
      if (i < 256) begin
        chk("clr_pc_src", {15'h0, a_pc_src}, 16'h0000);
      end
      chk("clr_rw_out", {15'h0, a_reg_write_out}, 16'h0000);
    end

    // Loads after the clear return zero; pipeline registers follow inputs.
    branch_in         = 1'b0;
    mem_write_in      = 1'b0;
    mem_read_in       = 1'b1;
    write_register_in = 5'd7;
    ALU_result_in     = 8'h00;
    tick();
    chk("ld00", {8'h0, a_read_data}, 16'h0000);
    chk("ld00_alu_out", {8'h0, a_ALU_result_out}, 16'h0000);
    chk("ld00_wreg", {11'h0, a_write_register_out}, 16'h0007);
    chk("ld00_m2r", {15'h0, a_mem_to_reg_out}, 16'h0001);
    chk("ld00_rw", {15'h0, a_reg_write_out}, 16'h0001);
    ALU_result_in = 8'h7F;
    tick();
    chk("ld7f", {8'h0, a_read_data}, 16'h0000);
    ALU_result_in     = 8'hFF;
    mem_to_reg_in     = 1'b0;
    reg_write_in      = 1'b0;
    write_register_in = 5'd31;
    tick();
    chk("ldff", {8'h0, a_read_data}, 16'h0000);
    chk("ldff_alu_out", {8'h0, a_ALU_result_out}, 16'h00FF);
    chk("ldff_wreg", {11'h0, a_write_register_out}, 16'h001F);
    chk("ldff_m2r", {15'h0, a_mem_to_reg_out}, 16'h0000);
    chk("ldff_rw", {15'h0, a_reg_write_out}, 16'h0000);

    // Store 0xA5 to 0x10, then load it.
    mem_to_reg_in = 1'b1;
    reg_write_in  = 1'b1;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b1;
    ALU_result_in = 8'h10;
    write_data_in = 8'hA5;
    tick();
    chk("st10_noread", {8'h0, a_read_data}, 16'h0000);
    mem_write_in = 1'b0;
    mem_read_in  = 1'b1;
    tick();
    chk("ld10", {8'h0, a_read_data}, 16'h00A5);
    mem_read_in = 1'b0;
    tick();
    chk("ld10_rd0", {8'h0, a_read_data}, 16'h0000);

    // Same-address load and store.
    mem_write_in  = 1'b1;
    ALU_result_in = 8'h20;
    write_data_in = 8'h11;
    tick();
    mem_read_in   = 1'b1;
    write_data_in = 8'h22;
    tick();
    chk("rw20_old", {8'h0, a_read_data}, 16'h0011);
    mem_write_in = 1'b0;
    tick();
    chk("rw20_new", {8'h0, a_read_data}, 16'h0022);

    // Branch resolution (combinational).
    branch_in  = 1'b1;
    zero_in    = 1'b1;
    PC_jump_in = 10'h155;
    #1;
    chk("br_taken", {15'h0, a_pc_src}, 16'h0001);
    chk("br_pc", {6'h0, a_PC_branch}, 16'h0155);
    chk("br_ex_alu", {8'h0, a_ex_mem_alu_result}, 16'h0020);
    zero_in    = 1'b0;
    PC_jump_in = 10'h2AA;
    #1;
    chk("br_nz", {15'h0, a_pc_src}, 16'h0000);
    chk("br_pc2", {6'h0, a_PC_branch}, 16'h02AA);
    branch_in = 1'b0;
    zero_in   = 1'b1;
    #1;
    chk("br_nobranch", {15'h0, a_pc_src}, 16'h0000);

    // Address wrap on the 16-byte instance.
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b1;
    ALU_result_in = 8'h25;
    write_data_in = 8'h3C;
    tick();
    mem_write_in  = 1'b0;
    mem_read_in   = 1'b1;
    ALU_result_in = 8'h05;
    tick();
    chk("wrap4_ld05", {8'h0, b_read_data}, 16'h003C);
    chk("wrap8_ld05", {8'h0, a_read_data}, 16'h0000);
    ALU_result_in = 8'h25;
    tick();
    chk("wrap8_ld25", {8'h0, a_read_data}, 16'h003C);

    // Reset mid-operation.
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b1;
    ALU_result_in = 8'h33;
    write_data_in = 8'h5A;
    tick();
    mem_write_in = 1'b0;
    mem_read_in  = 1'b1;
    tick();
    chk("mid_ld33_pre", {8'h0, a_read_data}, 16'h005A);
    reset         = 1'b1;
    mem_write_in  = 1'b1;
    write_data_in = 8'h77;
    branch_in     = 1'b1;
    zero_in       = 1'b1;
    reg_write_in  = 1'b1;
    tick();
    chk("mid_rst_busy", {15'h0, a_mem_busy}, 16'h0001);
    chk("mid_rst_rd", {8'h0, a_read_data}, 16'h0000);
    chk("mid_rst_rw", {15'h0, a_reg_write_out}, 16'h0000);
    chk("mid_rst_pc_src", {15'h0, a_pc_src}, 16'h0000);
    reset = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("mid_busy8", {15'h0, a_mem_busy}, (i < 256) ? 16'h0001 : 16'h0000);
      chk("mid_busy4", {15'h0, b_mem_busy}, (i < 16) ? 16'h0001 : 16'h0000);
      chk("mid_rw_out", {15'h0, a_reg_write_out}, 16'h0000);
      chk("mid_rd_out", {8'h0, a_read_data}, 16'h0000);
      chk("mid_pc_src", {15'h0, a_pc_src}, (i < 256) ? 16'h0000 : 16'h0001);
    end
    branch_in    = 1'b0;
    mem_write_in = 1'b0;
    mem_read_in  = 1'b1;
    tick();
    chk("mid_ld33_post", {8'h0, a_read_data}, 16'h0000);
    chk("mid_rw_run", {15'h0, a_reg_write_out}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 8-bit RISC-V pipeline. It consumes the EX/MEM pipeline register outputs (ALU result, store data, destination register, control bits, branch target, zero flag) and performs data-memory loads and stores against an internal byte-wide RAM. It resolves conditional branches and registers the MEM/WB pipeline outputs. After every reset it runs a clearing sequencer that zeroes the whole RAM, and it signals the hazard unit to stall while clearing is in progress.

## Interface

**Parameters**
- PC_SIZE, default 10: width of the branch target.
- ADDR_WIDTH, default 8: data RAM address width. Legal range 1..8. Depth is 2^ADDR_WIDTH bytes.

**Ports**
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- PC_jump_in, input, PC_SIZE: branch target from EX/MEM.
- zero_in, input, 1: ALU zero flag from EX/MEM.
- ALU_result_in, input, 8: ALU result, which is also the memory address.
- write_data_in, input, 8: store data.
- write_register_in, input, 5: destination register index.
- branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, input, 1 each: control bits from EX/MEM.
- ex_mem_alu_result, output, 8: combinational copy of ALU_result_in, feeding the EXE forwarding mux.
- pc_src, output, 1: branch taken, combinational.
- PC_branch, output, PC_SIZE: combinational copy of PC_jump_in.
- read_data, output, 8: registered load data.
- ALU_result_out, output, 8: registered ALU result.
- write_register_out, output, 5: registered destination register.
- mem_to_reg_out, reg_write_out, output, 1 each: registered control bits.
- mem_busy, output, 1: high while RAM clearing is in progress; drives the stall request.

## Operation

**States**
- INIT: clearing in progress.
- RUN: normal operation.

**State transitions**
- reset=1 forces INIT and sets init_addr to 0. No RAM write occurs while reset is high.
- In INIT with reset=0, each edge writes mem[init_addr] <= 0 and increments init_addr.
- On the edge that writes address 2^ADDR_WIDTH-1, the state moves to RUN. init_addr wraps to 0 and is unused in RUN.
- RUN persists until the next reset. A reset asserted mid-RUN re-enters INIT and re-clears the entire RAM.

**mem_busy**
- mem_busy = (state == INIT). It is a Moore output.

**INIT behaviour**
- All EX/MEM inputs are ignored. Stores are dropped and loads are not performed.
- The MEM/WB registers load bubbles: read_data, ALU_result_out and write_register_out are 0; mem_to_reg_out and reg_write_out are 0.
- pc_src = 0.

**RUN behaviour**
- Address is ALU_result_in[ADDR_WIDTH-1:0]. Upper bits are ignored, so the address wraps modulo the depth.
- Store: if mem_write_in=1, mem[addr] <= write_data_in at the edge.
- Load: read_data <= mem_read_in ? mem[addr] : 8'h00. The read is asynchronous and sees pre-edge contents.
- Load and store to the same address in the same cycle: read_data gets the old value; the new value is visible from the next cycle.
- ALU_result_out, write_register_out, mem_to_reg_out and reg_write_out register their inputs unconditionally.
- pc_src = branch_in & zero_in. PC_branch = PC_jump_in.
- There is no internal buffering. An upstream stall is the hazard unit's responsibility; this block accepts one EX/MEM entry per cycle.

## Timing

**Reset values**
- read_data = 0, ALU_result_out = 0, write_register_out = 0, mem_to_reg_out = 0, reg_write_out = 0.
- mem_busy = 1, pc_src = 0.
- ex_mem_alu_result and PC_branch follow their inputs.

**Clearing time**
- mem_busy is high throughout reset.
- It stays high for exactly 2^ADDR_WIDTH rising edges after the first edge sampled with reset=0.
- It then falls, at edge 2^ADDR_WIDTH after release.

**Latencies**
- Load: 1 cycle. Inputs present before edge N give read_data valid after edge N.
- Store: committed at edge N; visible to a load presented in cycle N+1.
- Pipeline registers: 1 cycle.
- pc_src, PC_branch and ex_mem_alu_result: 0 cycles (combinational).

## Test plan

- **Reset and clear** (ADDR_WIDTH=8): hold reset 3 cycles, then release. mem_busy must stay 1 for 256 edges, then go 0. A subsequent load from addresses 0x00, 0x7F and 0xFF must return read_data=0x00.
- **Store then load:** store 0xA5 to address 0x10, then load 0x10 in the next cycle. read_data=0xA5 one cycle after the load. Loading with mem_read_in=0 must give read_data=0x00.
- **Same-address load and store:** mem[0x20]=0x11; present mem_read=mem_write=1, addr=0x20, data=0x22. read_data=0x11; the next load returns 0x22.
- **Branch resolution:** branch_in=1, zero_in=1, PC_jump_in=0x155 gives pc_src=1 and PC_branch=0x155 in the same cycle. With zero_in=0, pc_src=0. During INIT, pc_src=0 regardless of inputs.
- **Reset mid-operation:** store 0x5A to 0x33, assert reset for 1 cycle, and attempt a store to 0x33 with 0x77 during INIT. After mem_busy falls, loading 0x33 must return 0x00. reg_write_out must be 0 throughout INIT.
- **Address wrap:** with ADDR_WIDTH=4, storing 0x3C to ALU_result 0x25 and then loading from 0x05 must return 0x3C. mem_busy must last 16 edges after reset release.
